config_frame_writer: RTL and testbench
======================================

Name: config_frame_writer

Overview:
Consumes the 32-bit word stream produced by the USB-UART bridge (word_write_strobe / write_data) and turns it into FABulous configuration frame writes. Parses a header word giving start column and word count, then routes each following data word onto frame_data_o with a one-hot, one-cycle column strobe. Sits between the USB word assembler and the fabric configuration chain; tracks protocol errors and counts completed frame writes.

Parameters:
NUM_COLUMNS, 16, number of frame strobe lines (1..256)
HDR_MARKER, 4'hA, value required in header bits [31:28]

Ports:
clk_i  input  1  system clock
reset_n_i  input  1  asynchronous active-low reset
enable_i  input  1  loader enable; when low, incoming words are ignored and FSM forced to IDLE
word_write_strobe_i  input  1  one-cycle pulse, write_data_i valid
write_data_i  input  32  assembled word from bridge
frame_data_o  output  32  frame data word, registered, held between writes
frame_strobe_o  output  NUM_COLUMNS  one-hot column write strobe, one cycle
busy_o  output  1  high while in DATA state
error_o  output  1  sticky protocol error flag
clear_error_i  input  1  synchronous clear of error_o
frames_written_o  output  16  count of data words written to fabric, wraps

Behaviour:
- Reset (async, reset_n_i low): state=IDLE, frame_data_o=0, frame_strobe_o=0, busy_o=0, error_o=0, frames_written_o=0, internal column/count regs=0.
- Accept = word_write_strobe_i && enable_i. No backpressure; an accept may occur every cycle.
- Header word fields: [31:28] marker, [27:16] reserved (ignored), [15:8] word count N, [7:0] start column C.
- IDLE: on accept, if [31:28]==HDR_MARKER and N!=0 and C<NUM_COLUMNS -> latch col=C, remaining=N, go DATA next cycle. Otherwise set error_o, stay IDLE, no strobe.
- DATA (busy_o=1): on accept, word is treated as raw data (any value, including marker-like patterns).
  - If col<NUM_COLUMNS: cycle after accept frame_data_o=word and frame_strobe_o has only bit col set for exactly one cycle; frames_written_o increments by 1 (16-bit wrap 0xFFFF->0x0000).
  - If col>=NUM_COLUMNS (run past edge): word dropped, no strobe, error_o set, transfer continues counting.
  - col increments (8-bit wide, saturates at 255), remaining decrements; when word with remaining==1 is accepted, return to IDLE; busy_o falls in the same cycle the final strobe is asserted.
- Latency: accept in cycle T -> frame_data_o/frame_strobe_o valid in T+1. frame_data_o holds last written value otherwise.
- Back-to-back accepts in consecutive cycles produce strobes in consecutive cycles on consecutive columns.
- Header immediately after the final data word (next cycle) is accepted normally.
- enable_i low: accepts ignored; if in DATA, FSM returns to IDLE next cycle, in-flight transfer abandoned, error_o set; an already-registered strobe still completes.
- clear_error_i clears error_o; if a new error occurs in the same cycle, set wins.
- frame_strobe_o is never multi-hot; never asserted in IDLE except the final-word strobe cycle.
- Reset mid-transfer: all state lost immediately, outputs to reset values.

Test Plan:
- Header 0xA000_0303 then words 0x11111111, 0x22222222, 0x33333333 -> strobes bits 3,4,5 one cycle each, frame_data_o matching per cycle, frames_written_o=3, busy_o low after last, error_o=0.
- Header 0x5000_0100 (bad marker) and 0xA000_0000 (N=0) and 0xA000_0114 with NUM_COLUMNS=16 (C=20) -> no strobes, error_o=1 after each, state IDLE; clear_error_i -> error_o=0.
- Header 0xA000_030E, NUM_COLUMNS=16, three data words -> strobes bits 14,15, third word dropped, error_o=1, frames_written_o=2, FSM back in IDLE.
- Header 0xA000_0200 then data words on consecutive cycles, then header 0xA000_0105 the cycle after, then word 0xDEADBEEF -> strobes bits 0,1 back to back, then bit 5 with 0xDEADBEEF.
- Header 0xA000_0400, one data word, drop enable_i -> one strobe on bit 0, IDLE next cycle, error_o=1, later strobes ignored until re-enabled.
- Reset asserted mid-DATA after 1 of 4 words, released, header 0xA000_0102 + word 0xCAFEF00D -> all outputs zero during reset, then a single strobe on bit 2, frames_written_o=1.

Source files
------------

// File: rtl/config_frame_if.sv
// Word-stream input and frame-write output bundle between the USB word assembler,
// the frame writer and the fabric configuration chain.
interface config_frame_if #(
    parameter int unsigned NUM_COLUMNS = 16
);
    logic                   word_write_strobe_i;
    logic [31:0]            write_data_i;
    logic [31:0]            frame_data_o;
    logic [NUM_COLUMNS-1:0] frame_strobe_o;

    modport master (
        output word_write_strobe_i,
        output write_data_i,
        input  frame_data_o,
        input  frame_strobe_o
    );

    modport slave (
        input  word_write_strobe_i,
        input  write_data_i,
        output frame_data_o,
        output frame_strobe_o
    );
endinterface

// File: rtl/config_frame_writer.sv
// Parses header words from the bridge word stream and routes the following data
// words onto the frame bus with a one-hot, one-cycle column strobe.
module config_frame_writer #(
    parameter int unsigned NUM_COLUMNS = 16,
    parameter logic [3:0]  HDR_MARKER  = 4'hA
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          enable_i,
    input  logic          clear_error_i,
    config_frame_if.slave bus,
    output logic          busy_o,
    output logic          error_o,
    output logic [15:0]   frames_written_o
);
    localparam int unsigned COL_W = 9;

    typedef enum logic {
        S_IDLE,
        S_DATA
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_col;
    logic [7:0]             w_col_nxt;
    logic [7:0]             r_remaining;
    logic [7:0]             w_rem_nxt;
    logic [31:0]            r_frame_data;
    logic [NUM_COLUMNS-1:0] r_frame_strobe;
    logic                   r_busy;
    logic                   r_error;
    logic [15:0]            r_frames_written;

    logic       w_accept;
    logic [7:0] w_hdr_count;
    logic [7:0] w_hdr_col;
    logic       w_hdr_ok;
    logic       w_col_in_range;
    logic       w_write;
    logic       w_err_set;

    assign w_accept       = bus.word_write_strobe_i && enable_i;
    assign w_hdr_count    = bus.write_data_i[15:8];
    assign w_hdr_col      = bus.write_data_i[7:0];
    assign w_hdr_ok       = (bus.write_data_i[31:28] == HDR_MARKER) &&
                            (w_hdr_count != 8'd0) &&
                            (COL_W'(w_hdr_col) < COL_W'(NUM_COLUMNS));
    assign w_col_in_range = COL_W'(r_col) < COL_W'(NUM_COLUMNS);

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_col       <= 8'd0;
            r_remaining <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_remaining <= w_rem_nxt;
        end
    end

    // Header parsing, data routing and error detection
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_rem_nxt   = r_remaining;
        w_write     = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_hdr_ok) begin
                        w_state_nxt = S_DATA;
                        w_col_nxt   = w_hdr_col;
                        w_rem_nxt   = w_hdr_count;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (!enable_i) begin
                    // Disabling mid-transfer abandons the remaining words
                    w_state_nxt = S_IDLE;
                    w_err_set   = 1'b1;
                end else if (w_accept) begin
                    w_write   = w_col_in_range;
                    w_err_set = !w_col_in_range;
                    w_col_nxt = (r_col == 8'hFF) ? r_col : r_col + 8'd1;
                    w_rem_nxt = r_remaining - 8'd1;
                    if (r_remaining == 8'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered frame outputs, status and counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_frame_data     <= 32'd0;
            r_frame_strobe   <= '0;
            r_busy           <= 1'b0;
            r_error          <= 1'b0;
            r_frames_written <= 16'd0;
        end else begin
            r_busy         <= (w_state_nxt == S_DATA);
            r_frame_strobe <= w_write ? (NUM_COLUMNS'(1) << r_col) : '0;
            if (w_write) begin
                r_frame_data     <= bus.write_data_i;
                r_frames_written <= r_frames_written + 16'd1;
            end
            if (w_err_set) begin
                r_error <= 1'b1;
            end else if (clear_error_i) begin
                r_error <= 1'b0;
            end
        end
    end

    assign bus.frame_data_o   = r_frame_data;
    assign bus.frame_strobe_o = r_frame_strobe;
    assign busy_o             = r_busy;
    assign error_o            = r_error;
    assign frames_written_o   = r_frames_written;
endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer: directed vector table, corner-case
// sequences and random word streams against a transaction-level reference model.
module tb_config_frame_writer;
    localparam int unsigned NC = 16;

    logic        clk_i         = 1'b0;
    logic        reset_n_i     = 1'b0;
    logic        enable_i      = 1'b0;
    logic        clear_error_i = 1'b0;
    logic        busy_o;
    logic        error_o;
    logic [15:0] frames_written_o;

    config_frame_if #(.NUM_COLUMNS(NC)) bus ();

    config_frame_writer #(.NUM_COLUMNS(NC), .HDR_MARKER(4'hA)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .enable_i         (enable_i),
        .clear_error_i    (clear_error_i),
        .bus              (bus),
        .busy_o           (busy_o),
        .error_o          (error_o),
        .frames_written_o (frames_written_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: tracks an open transfer as (next column, words left)
    bit          m_active;
    int          m_col;
    int          m_rem;
    bit          m_err;
    logic [31:0] m_data;
    int          m_cnt;
    int          m_idx;

    typedef struct {
        bit          en;
        bit          we;
        logic [31:0] data;
        bit          clr;
        int          idx;
        logic [31:0] q;
        bit          busy;
        bit          err;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit en, bit we, logic [31:0] data, bit clr,
                                int idx, logic [31:0] q, bit busy, bit err, int cnt);
        vec_t v;
        v.en = en; v.we = we; v.data = data; v.clr = clr;
        v.idx = idx; v.q = q; v.busy = busy; v.err = err; v.cnt = cnt;
        return v;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_col = 0; m_rem = 0; m_err = 1'b0;
        m_data = 32'd0; m_cnt = 0; m_idx = -1;
    endtask

    task automatic model_step(input bit en, input bit we, input logic [31:0] d, input bit clr);
        bit eset;
        eset  = 1'b0;
        m_idx = -1;
        if (m_active && !en) begin
            m_active = 1'b0;
            eset     = 1'b1;
        end else if (en && we) begin
            if (!m_active) begin
                if (d[31:28] == 4'hA && d[15:8] != 8'd0 && int'(d[7:0]) < int'(NC)) begin
                    m_active = 1'b1;
                    m_col    = int'(d[7:0]);
                    m_rem    = int'(d[15:8]);
                end else begin
                    eset = 1'b1;
                end
            end else begin
                if (m_col < int'(NC)) begin
                    m_idx  = m_col;
                    m_data = d;
                    m_cnt  = (m_cnt + 1) % 65536;
                end else begin
                    eset = 1'b1;
                end
                m_col = (m_col < 255) ? m_col + 1 : 255;
                m_rem = m_rem - 1;
                if (m_rem == 0) m_active = 1'b0;
            end
        end
        if (eset) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic [31:0] q,
                                 input bit busy, input bit err, input int cnt);
        logic [31:0] exp_strobe;
        exp_strobe = (idx < 0) ? 32'd0 : (32'd1 << idx);
        check({tag, ".strobe"}, 32'(bus.frame_strobe_o), exp_strobe);
        check({tag, ".data"},   bus.frame_data_o, q);
        check({tag, ".busy"},   32'(busy_o), 32'(busy));
        check({tag, ".error"},  32'(error_o), 32'(err));
        check({tag, ".count"},  32'(frames_written_o), 32'(cnt));
    endtask

    task automatic check_model(input string tag);
        check_outputs(tag, m_idx, m_data, m_active, m_err, m_cnt);
    endtask

    // Drive one cycle of inputs at the falling edge, sample just after the rising edge
    task automatic step(input bit en, input bit we, input logic [31:0] d, input bit clr);
        @(negedge clk_i);
        enable_i                = en;
        bus.word_write_strobe_i = we;
        bus.write_data_i        = d;
        clear_error_i           = clr;
        model_step(en, we, d, clr);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bus.word_write_strobe_i = 1'b0;
        bus.write_data_i        = 32'd0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_outputs("reset", -1, 32'd0, 1'b0, 1'b0, 0);
        reset_n_i = 1'b1;
        enable_i  = 1'b1;

        // Directed table: en, we, data, clr | strobe idx, data, busy, error, count
        vecs.push_back(mk(1, 1, 32'hA000_0303, 0, -1, 32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h1111_1111, 0,  3, 32'h1111_1111, 1, 0, 1));
        vecs.push_back(mk(1, 1, 32'h2222_2222, 0,  4, 32'h2222_2222, 1, 0, 2));
        vecs.push_back(mk(1, 1, 32'h3333_3333, 0,  5, 32'h3333_3333, 0, 0, 3));
        vecs.push_back(mk(1, 0, 32'h0000_0000, 0, -1, 32'h3333_3333, 0, 0, 3));
        vecs.push_back(mk(1, 1, 32'h5000_0100, 0, -1, 32'h3333_3333, 0, 1, 3));
        vecs.push_back(mk(1, 0, 32'h0000_0000, 1, -1, 32'h3333_3333, 0, 0, 3));
        vecs.push_back(mk(1, 1, 32'hA000_0000, 0, -1, 32'h3333_3333, 0, 1, 3));
        vecs.push_back(mk(1, 0, 32'h0000_0000, 1, -1, 32'h3333_3333, 0, 0, 3));
        vecs.push_back(mk(1, 1, 32'hA000_0114, 0, -1, 32'h3333_3333, 0, 1, 3));
        vecs.push_back(mk(1, 0, 32'h0000_0000, 1, -1, 32'h3333_3333, 0, 0, 3));
        vecs.push_back(mk(1, 1, 32'hA000_030E, 0, -1, 32'h3333_3333, 1, 0, 3));
        vecs.push_back(mk(1, 1, 32'hAAAA_AAAA, 0, 14, 32'hAAAA_AAAA, 1, 0, 4));
        vecs.push_back(mk(1, 1, 32'hBBBB_BBBB, 0, 15, 32'hBBBB_BBBB, 1, 0, 5));
        vecs.push_back(mk(1, 1, 32'hCCCC_CCCC, 0, -1, 32'hBBBB_BBBB, 0, 1, 5));
        vecs.push_back(mk(1, 0, 32'h0000_0000, 1, -1, 32'hBBBB_BBBB, 0, 0, 5));
        vecs.push_back(mk(1, 1, 32'hA000_0200, 0, -1, 32'hBBBB_BBBB, 1, 0, 5));
        vecs.push_back(mk(1, 1, 32'h0101_0101, 0,  0, 32'h0101_0101, 1, 0, 6));
        vecs.push_back(mk(1, 1, 32'h0202_0202, 0,  1, 32'h0202_0202, 0, 0, 7));
        vecs.push_back(mk(1, 1, 32'hA000_0105, 0, -1, 32'h0202_0202, 1, 0, 7));
        vecs.push_back(mk(1, 1, 32'hDEAD_BEEF, 0,  5, 32'hDEAD_BEEF, 0, 0, 8));
        vecs.push_back(mk(1, 0, 32'h0000_0000, 0, -1, 32'hDEAD_BEEF, 0, 0, 8));
        vecs.push_back(mk(1, 1, 32'hA000_0400, 0, -1, 32'hDEAD_BEEF, 1, 0, 8));
        vecs.push_back(mk(1, 1, 32'h1234_5678, 0,  0, 32'h1234_5678, 1, 0, 9));
        vecs.push_back(mk(0, 1, 32'h8765_4321, 0, -1, 32'h1234_5678, 0, 1, 9));
        vecs.push_back(mk(0, 1, 32'h9999_9999, 0, -1, 32'h1234_5678, 0, 1, 9));
        vecs.push_back(mk(0, 1, 32'hA000_0101, 0, -1, 32'h1234_5678, 0, 1, 9));
        vecs.push_back(mk(1, 0, 32'h0000_0000, 1, -1, 32'h1234_5678, 0, 0, 9));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].we, vecs[i].data, vecs[i].clr);
            check_outputs($sformatf("vec%0d", i), vecs[i].idx, vecs[i].q,
                          vecs[i].busy, vecs[i].err, vecs[i].cnt);
        end

        // Clear and new error in the same cycle: set wins
        step(1, 1, 32'h3000_0101, 1);
        check_model("err_vs_clear");
        check("err_vs_clear.const", 32'(error_o), 32'd1);
        step(1, 0, 32'd0, 1);
        check_model("err_cleared");

        // Reset in the middle of a four-word transfer
        step(1, 1, 32'hA000_0400, 0);
        check_model("rst_hdr");
        step(1, 1, 32'h5555_0001, 0);
        check_model("rst_word1");
        @(negedge clk_i);
        bus.word_write_strobe_i = 1'b0;
        reset_n_i               = 1'b0;
        model_reset();
        #1;
        check_model("rst_async");
        @(posedge clk_i);
        #1;
        check_model("rst_held");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1, 1, 32'hA000_0102, 0);
        check_model("post_rst_hdr");
        step(1, 1, 32'hCAFE_F00D, 0);
        check_model("post_rst_word");
        check("post_rst.strobe_const", 32'(bus.frame_strobe_o), 32'h0000_0004);
        check("post_rst.count_const", 32'(frames_written_o), 32'd1);
        step(1, 0, 32'd0, 0);
        check_model("post_rst_idle");

        // Random word stream with occasional enable drops and error clears
        for (int n = 0; n < 3000; n++) begin
            bit          en;
            bit          we;
            bit          clr;
            logic [31:0] d;
            en  = ($urandom_range(0, 15) != 0);
            we  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) begin
                d = {(($urandom_range(0, 7) == 0) ? 4'h5 : 4'hA), 12'($urandom),
                     8'($urandom_range(0, 5)), 8'($urandom_range(0, 20))};
            end else begin
                d = $urandom;
            end
            step(en, we, d, clr);
            check_model($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
